// File: rtl/fifo_rd_ctrl.sv
// Read-side sequencer for the UART FIFO: decides when to drain (threshold, idle
// timeout or flush), pops one byte at a time and hands it to the UART transmitter.
module fifo_rd_ctrl #(
  parameter int unsigned BURST_TH = 16,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             enable,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic [8:0]       fifo_cnt,
  input  logic [7:0]       fifo_dout,
  output logic             fifo_rd_en,
  input  logic             tx_busy,
  output logic             tx_en,
  output logic [7:0]       tx_data,
  output logic             drain_active,
  output logic [CNT_W-1:0] byte_cnt
);

  localparam int unsigned TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);
  // 32-bit compare so a threshold above 256 can never be reached
  localparam logic [31:0] TH = 32'(BURST_TH);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND,
    ACK,
    BUSY
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] idle_tmr_q, idle_tmr_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             drain_q;

  logic at_th;
  logic start_drain;

  assign at_th       = ({23'd0, fifo_cnt} >= TH);
  assign start_drain = enable && !fifo_empty &&
                       (at_th || (idle_tmr_q == TMR_MAX) || flush);

  always_comb begin
    state_d    = state_q;
    idle_tmr_d = idle_tmr_q;
    tx_data_d  = tx_data_q;
    byte_cnt_d = byte_cnt_q;
    fifo_rd_en = 1'b0;
    tx_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_drain) begin
          state_d    = READ;
          idle_tmr_d = '0;
        end else if (fifo_empty) begin
          idle_tmr_d = '0;
        end else if (idle_tmr_q != TMR_MAX) begin
          idle_tmr_d = idle_tmr_q + TMR_W'(1);
        end
      end
      READ: begin
        fifo_rd_en = 1'b1;
        state_d    = WAIT;
      end
      // FIFO read data is valid here, one cycle after the pop
      WAIT: begin
        tx_data_d = fifo_dout;
        state_d   = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_en      = 1'b1;
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          state_d    = ACK;
        end
      end
      ACK: begin
        if (tx_busy) begin
          state_d = BUSY;
        end
      end
      // Drain continues until empty; only enable can cut it short
      BUSY: begin
        if (!tx_busy) begin
          state_d = (enable && !fifo_empty) ? READ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      idle_tmr_q <= '0;
      tx_data_q  <= '0;
      byte_cnt_q <= '0;
      drain_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_tmr_q <= idle_tmr_d;
      tx_data_q  <= tx_data_d;
      byte_cnt_q <= byte_cnt_d;
      drain_q    <= (state_d != IDLE);
    end
  end

  assign tx_data      = tx_data_q;
  assign byte_cnt     = byte_cnt_q;
  assign drain_active = drain_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a behavioural FIFO (1-cycle read latency)
// and a UART TX model that stays busy for a fixed frame after each tx_en.
module tb_fifo_rd_ctrl;

  localparam int BURST_TH = 16;
  localparam int TIMEOUT  = 1000;
  localparam int CNT_W    = 16;
  localparam int FRAME    = 10;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             enable;
  logic             flush;
  logic             fifo_empty;
  logic [8:0]       fifo_cnt;
  logic [7:0]       fifo_dout;
  logic             fifo_rd_en;
  logic             tx_busy;
  logic             tx_en;
  logic [7:0]       tx_data;
  logic             drain_active;
  logic [CNT_W-1:0] byte_cnt;

  fifo_rd_ctrl #(.BURST_TH(BURST_TH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_cnt(fifo_cnt), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .tx_busy(tx_busy), .tx_en(tx_en),
    .tx_data(tx_data), .drain_active(drain_active), .byte_cnt(byte_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // Behavioural FIFO
  logic       wr_en;
  logic [7:0] wdata;
  logic [7:0] mem [256];
  logic [7:0] wp = 8'd0, rp = 8'd0;
  logic [8:0] cnt = 9'd0;
  logic [7:0] dout_r = 8'd0;

  assign fifo_cnt   = cnt;
  assign fifo_empty = (cnt == 9'd0);
  assign fifo_dout  = dout_r;

  always @(posedge sys_clk) begin
    if (wr_en) begin
      mem[wp] <= wdata;
      wp      <= wp + 8'd1;
    end
    if (fifo_rd_en) begin
      dout_r <= mem[rp];
      rp     <= rp + 8'd1;
    end
    cnt <= cnt + {8'd0, wr_en} - {8'd0, fifo_rd_en};
  end

  // UART TX model and monitors
  logic       hold_busy;
  int         tx_cnt = 0;
  int         cyc = 0;
  int         overlap = 0;
  int         rd_pulses = 0;
  logic [7:0] rxq[$];

  assign tx_busy = (tx_cnt != 0) || hold_busy;

  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (tx_en) begin
      rxq.push_back(tx_data);
      tx_cnt <= FRAME;
    end else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
    end
    if (fifo_rd_en) rd_pulses <= rd_pulses + 1;
    if (fifo_rd_en && tx_en) overlap <= overlap + 1;
  end

  int checks = 0;
  int failures = 0;
  int last_wr_cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge sys_clk);
    wr_en = 1'b1;
    wdata = b;
    last_wr_cyc = cyc;
    @(posedge sys_clk);
  endtask

  task automatic end_write();
    @(negedge sys_clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int max, input string tag);
    int k;
    k = 0;
    while (!drain_active && k < max) begin @(negedge sys_clk); k++; end
    while (drain_active && k < max) begin @(negedge sys_clk); k++; end
    if (k >= max) check_val({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int lat;
    int rd0;
    int bad;
    int txn;
    int k;
    bit got;
    sys_rst = 1'b1; enable = 1'b0; flush = 1'b0; hold_busy = 1'b0;
    wr_en = 1'b0; wdata = 8'd0;

    // Reset state
    repeat (3) @(negedge sys_clk);
    check_val("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check_val("rst_tx_en", {31'd0, tx_en}, 32'd0);
    check_val("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check_val("rst_drain", {31'd0, drain_active}, 32'd0);
    check_val("rst_byte_cnt", {16'd0, byte_cnt}, 32'd0);
    sys_rst = 1'b0;
    enable  = 1'b1;

    // Threshold drain: 16 bytes 0x00..0x0F
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    end_write();
    check_val("th_cnt16", {23'd0, fifo_cnt}, 32'd16);
    check_val("th_no_pop_yet", {31'd0, fifo_rd_en}, 32'd0);
    @(negedge sys_clk);
    check_val("th_pop", {31'd0, fifo_rd_en}, 32'd1);
    check_val("th_drain", {31'd0, drain_active}, 32'd1);
    wait_done(2000, "th");
    check_val("th_nbytes", rxq.size(), 32'd16);
    bad = 0;
    for (int i = 0; i < 16; i++) if (i >= rxq.size() || rxq[i] != 8'(i)) bad++;
    check_val("th_order_errs", bad, 32'd0);
    check_val("th_byte_cnt", {16'd0, byte_cnt}, 32'd16);
    check_val("th_empty", {23'd0, fifo_cnt}, 32'd0);

    // Timeout drain: 3 bytes below threshold
    rxq.delete();
    write_byte(8'h30);
    lat = last_wr_cyc;
    write_byte(8'h31);
    write_byte(8'h32);
    end_write();
    got = 0;
    k = 0;
    while (!got && k < 3000) begin
      @(negedge sys_clk);
      k++;
      if (fifo_rd_en) got = 1;
    end
    check_val("to_found", {31'd0, got}, 32'd1);
    check_val("to_latency", cyc - lat - 1, TIMEOUT + 1);
    check_val("to_tmr_clr", {22'd0, dut.idle_tmr_q}, 32'd0);
    wait_done(2000, "to");
    check_val("to_nbytes", rxq.size(), 32'd3);
    check_val("to_b0", (rxq.size() > 0) ? rxq[0] : 8'h00, 32'h30);
    check_val("to_b2", (rxq.size() > 2) ? rxq[2] : 8'h00, 32'h32);
    check_val("to_byte_cnt", {16'd0, byte_cnt}, 32'd19);

    // Flush: single byte 0xA5
    rxq.delete();
    write_byte(8'hA5);
    end_write();
    flush = 1'b1;
    lat = cyc;
    rd0 = rd_pulses;
    got = 0;
    k = 0;
    while (!got && k < 50) begin
      @(negedge sys_clk);
      k++;
      if (tx_en) got = 1;
    end
    check_val("fl_latency", cyc - lat, 32'd3);
    check_val("fl_data", {24'd0, tx_data}, 32'hA5);
    wait_done(200, "fl");
    repeat (10) @(negedge sys_clk);
    check_val("fl_pops", rd_pulses - rd0, 32'd1);
    check_val("fl_idle", {31'd0, drain_active}, 32'd0);
    flush = 1'b0;

    // TX backpressure in SEND
    rxq.delete();
    hold_busy = 1'b1;
    write_byte(8'h5C);
    end_write();
    flush = 1'b1;
    k = 0;
    while (!fifo_rd_en && k < 50) begin @(negedge sys_clk); k++; end
    repeat (2) @(negedge sys_clk);
    txn = 0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx_en) txn++;
      if (tx_data != 8'h5C) bad++;
      @(negedge sys_clk);
    end
    check_val("bp_no_tx_en", txn, 32'd0);
    check_val("bp_data_stable", bad, 32'd0);
    check_val("bp_drain", {31'd0, drain_active}, 32'd1);
    hold_busy = 1'b0;
    wait_done(200, "bp");
    check_val("bp_ntx", rxq.size(), 32'd1);
    check_val("bp_byte", (rxq.size() > 0) ? rxq[0] : 8'h00, 32'h5C);
    flush = 1'b0;

    // Enable drop during byte 5 of a 32-byte drain
    enable = 1'b0;
    for (int i = 0; i < 32; i++) write_byte(8'(8'h40 + i));
    end_write();
    rxq.delete();
    enable = 1'b1;
    got = 0;
    k = 0;
    while (!got && k < 2000) begin
      @(negedge sys_clk);
      k++;
      if (tx_en && rxq.size() == 4) begin
        enable = 1'b0;
        got = 1;
      end
    end
    check_val("en_found_b5", {31'd0, got}, 32'd1);
    wait_done(200, "en");
    repeat (5) @(negedge sys_clk);
    check_val("en_nbytes", rxq.size(), 32'd5);
    check_val("en_byte_cnt", {16'd0, byte_cnt}, 32'd26);
    check_val("en_remaining", {23'd0, fifo_cnt}, 32'd27);
    check_val("en_b4", (rxq.size() > 4) ? rxq[4] : 8'h00, 32'h44);
    rxq.delete();
    enable = 1'b1;
    wait_done(3000, "re");
    check_val("re_nbytes", rxq.size(), 32'd27);
    bad = 0;
    for (int i = 0; i < 27; i++) if (i >= rxq.size() || rxq[i] != 8'(8'h45 + i)) bad++;
    check_val("re_order_errs", bad, 32'd0);
    check_val("re_byte_cnt", {16'd0, byte_cnt}, 32'd53);
    check_val("re_empty", {23'd0, fifo_cnt}, 32'd0);

    // Reset asserted in WAIT
    rxq.delete();
    flush = 1'b1;
    write_byte(8'h70);
    write_byte(8'h71);
    end_write();
    k = 0;
    while (!fifo_rd_en && k < 50) begin @(negedge sys_clk); k++; end
    check_val("rs_pop_seen", {31'd0, fifo_rd_en}, 32'd1);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check_val("rs_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check_val("rs_tx_en", {31'd0, tx_en}, 32'd0);
    check_val("rs_tx_data", {24'd0, tx_data}, 32'd0);
    check_val("rs_drain", {31'd0, drain_active}, 32'd0);
    check_val("rs_byte_cnt", {16'd0, byte_cnt}, 32'd0);
    sys_rst = 1'b0;
    wait_done(200, "rs");
    check_val("rs_ntx", rxq.size(), 32'd1);
    check_val("rs_head", (rxq.size() > 0) ? rxq[0] : 8'h00, 32'h71);
    check_val("rs_byte_cnt_after", {16'd0, byte_cnt}, 32'd1);
    flush = 1'b0;

    check_val("no_rd_tx_overlap", overlap, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
